// File: rtl/interrupt_request_ctrl.sv
// interrupt_request_ctrl: edge-captured maskable and NMI interrupt source for the multicycle CPU.
// Define INT_PRIORITY_ROTATE_EN for rotating maskable priority; the default is fixed, lowest index first.
module interrupt_request_ctrl #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               nmi_in,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               cpu_ack,
  input  logic               cpu_ack_ina,
  input  logic               eoi,
  output logic               INT,
  output logic               NMI,
  output logic               INTD,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_IRQ-1:0] pending
);

  typedef enum logic [1:0] {IDLE, INT_REQ, INT_SERV} state_t;

  state_t               state_q, state_d;
  logic [NUM_IRQ-1:0]   irq_prev_q, irq_prev_d;
  logic                 nmi_prev_q, nmi_prev_d;
  logic [NUM_IRQ-1:0]   pending_q, pending_d;
  logic [NUM_IRQ-1:0]   mask_q, mask_d;
  logic                 nmi_pend_q, nmi_pend_d;
  logic                 nmi_srv_q, nmi_srv_d;
  logic [ID_W-1:0]      irq_id_q, irq_id_d;
  logic                 int_q, int_d;
  logic                 nmi_q, nmi_d;
  logic                 intd_q, intd_d;
`ifdef INT_PRIORITY_ROTATE_EN
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [2*NUM_IRQ-1:0] req_dbl;
  logic [NUM_IRQ-1:0]   req_rot;
  int                   sel_pos;
`endif

  logic [NUM_IRQ-1:0]   irq_rise;
  logic                 nmi_rise;
  logic [NUM_IRQ-1:0]   req_vec;
  logic [NUM_IRQ-1:0]   pend_clr;
  logic                 int_ack;
  logic                 nmi_ack;
  logic                 sel_found;
  logic [ID_W-1:0]      sel_idx;

  assign irq_rise = irq_in & ~irq_prev_q;
  assign nmi_rise = nmi_in & ~nmi_prev_q;
  assign req_vec  = pending_q & mask_q;
  assign int_ack  = cpu_ack & cpu_ack_ina & (state_q == INT_REQ);
  assign nmi_ack  = cpu_ack & ~cpu_ack_ina & nmi_pend_q & ~nmi_srv_q;

`ifdef INT_PRIORITY_ROTATE_EN
  // Rotate the request vector so bit 0 is the line at ptr, then take the first set bit.
  always_comb begin
    req_dbl   = {req_vec, req_vec} >> ptr_q;
    req_rot   = req_dbl[NUM_IRQ-1:0];
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_pos   = 0;
    for (int off = 0; off < NUM_IRQ; off++) begin
      if (!sel_found && req_rot[off]) begin
        sel_found = 1'b1;
        sel_pos   = int'(ptr_q) + off;
        if (sel_pos >= NUM_IRQ) begin
          sel_pos = sel_pos - NUM_IRQ;
        end
        sel_idx = ID_W'(sel_pos);
      end
    end
  end
`else
  always_comb begin
    sel_found = |req_vec;
    sel_idx   = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req_vec[i]) begin
        sel_idx = ID_W'(i);
      end
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    irq_id_d   = irq_id_q;
    irq_prev_d = irq_in;
    nmi_prev_d = nmi_in;
    mask_d     = mask_we ? mask_wdata : mask_q;
    pend_clr   = '0;
`ifdef INT_PRIORITY_ROTATE_EN
    ptr_d      = ptr_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d  = INT_REQ;
          irq_id_d = sel_idx;
        end
      end
      INT_REQ: begin
        // An ack beats a mask clear that lands in the same cycle.
        if (int_ack) begin
          state_d            = INT_SERV;
          pend_clr[irq_id_q] = 1'b1;
`ifdef INT_PRIORITY_ROTATE_EN
          if (irq_id_q == ID_W'(NUM_IRQ - 1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = irq_id_q + ID_W'(1);
          end
`endif
        end else if (!mask_q[irq_id_q]) begin
          state_d = IDLE;
        end
      end
      INT_SERV: begin
        if (eoi && !nmi_srv_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    pending_d  = (pending_q & ~pend_clr) | irq_rise;
    nmi_pend_d = (nmi_pend_q & ~nmi_ack) | nmi_rise;

    // The NMI handler is the innermost level, so eoi retires it first.
    nmi_srv_d = nmi_srv_q;
    if (eoi && nmi_srv_q) begin
      nmi_srv_d = 1'b0;
    end
    if (nmi_ack) begin
      nmi_srv_d = 1'b1;
    end

    int_d  = (state_d == INT_REQ);
    nmi_d  = nmi_pend_d & ~nmi_srv_d;
    intd_d = (state_d == INT_SERV) | nmi_srv_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      irq_prev_q <= '0;
      nmi_prev_q <= 1'b0;
      pending_q  <= '0;
      mask_q     <= '0;
      nmi_pend_q <= 1'b0;
      nmi_srv_q  <= 1'b0;
      irq_id_q   <= '0;
      int_q      <= 1'b0;
      nmi_q      <= 1'b0;
      intd_q     <= 1'b0;
`ifdef INT_PRIORITY_ROTATE_EN
      ptr_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      irq_prev_q <= irq_prev_d;
      nmi_prev_q <= nmi_prev_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      nmi_pend_q <= nmi_pend_d;
      nmi_srv_q  <= nmi_srv_d;
      irq_id_q   <= irq_id_d;
      int_q      <= int_d;
      nmi_q      <= nmi_d;
      intd_q     <= intd_d;
`ifdef INT_PRIORITY_ROTATE_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  assign INT     = int_q;
  assign NMI     = nmi_q;
  assign INTD    = intd_q;
  assign irq_id  = irq_id_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_interrupt_request_ctrl.sv
// Scoreboard bench for interrupt_request_ctrl: each driven cycle queues its expected outputs,
// which a monitor pops and compares one clock later.
module tb_interrupt_request_ctrl;

  localparam int NUM_IRQ = 8;
  localparam int ID_W    = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NUM_IRQ-1:0] irq_in;
  logic               nmi_in;
  logic               mask_we;
  logic [NUM_IRQ-1:0] mask_wdata;
  logic               cpu_ack;
  logic               cpu_ack_ina;
  logic               eoi;
  logic               INT;
  logic               NMI;
  logic               INTD;
  logic [ID_W-1:0]    irq_id;
  logic [NUM_IRQ-1:0] pending;

  typedef struct {
    string      tag;
    logic       expInt;
    logic       expNmi;
    logic       expIntd;
    logic [2:0] expId;
    logic [7:0] expPend;
  } exp_t;

  exp_t sbQueue[$];
  exp_t popped;
  int   compareCount  = 0;
  int   mismatchCount = 0;

  interrupt_request_ctrl #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .nmi_in(nmi_in),
    .mask_we(mask_we), .mask_wdata(mask_wdata), .cpu_ack(cpu_ack),
    .cpu_ack_ina(cpu_ack_ina), .eoi(eoi), .INT(INT), .NMI(NMI),
    .INTD(INTD), .irq_id(irq_id), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs and queue what the outputs must be after the next rising edge.
  task automatic applyStimulus(input string tag, input logic [7:0] irq, input logic nmi,
                               input logic mwe, input logic [7:0] mwd, input logic ack,
                               input logic ina, input logic eoiIn, input logic eInt,
                               input logic eNmi, input logic eIntd, input logic [2:0] eId,
                               input logic [7:0] ePend);
    exp_t e;
    @(negedge clk);
    irq_in      = irq;
    nmi_in      = nmi;
    mask_we     = mwe;
    mask_wdata  = mwd;
    cpu_ack     = ack;
    cpu_ack_ina = ina;
    eoi         = eoiIn;
    e.tag     = tag;
    e.expInt  = eInt;
    e.expNmi  = eNmi;
    e.expIntd = eIntd;
    e.expId   = eId;
    e.expPend = ePend;
    sbQueue.push_back(e);
  endtask

  task automatic doReset(input logic [7:0] irqHold);
    @(negedge clk);
    #2;
    rst_n       = 1'b0;
    irq_in      = irqHold;
    nmi_in      = 1'b0;
    mask_we     = 1'b0;
    mask_wdata  = '0;
    cpu_ack     = 1'b0;
    cpu_ack_ina = 1'b0;
    eoi         = 1'b0;
    #1;
    checkOutput("rst_INT", 32'(INT), 32'd0);
    checkOutput("rst_NMI", 32'(NMI), 32'd0);
    checkOutput("rst_INTD", 32'(INTD), 32'd0);
    checkOutput("rst_id", 32'(irq_id), 32'd0);
    checkOutput("rst_pend", 32'(pending), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  always begin
    @(posedge clk);
    #1;
    if (sbQueue.size() > 0) begin
      popped = sbQueue.pop_front();
      checkOutput({popped.tag, "_INT"}, 32'(INT), 32'(popped.expInt));
      checkOutput({popped.tag, "_NMI"}, 32'(NMI), 32'(popped.expNmi));
      checkOutput({popped.tag, "_INTD"}, 32'(INTD), 32'(popped.expIntd));
      checkOutput({popped.tag, "_id"}, 32'(irq_id), 32'(popped.expId));
      checkOutput({popped.tag, "_pend"}, 32'(pending), 32'(popped.expPend));
    end
  end

  function automatic logic [2:0] rotId(input int k);
`ifdef INT_PRIORITY_ROTATE_EN
    return 3'(k % 2);
`else
    return 3'd0;
`endif
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0] e;
    logic [7:0] leftover;
    rst_n = 1'b0;
    irq_in = '0; nmi_in = 1'b0; mask_we = 1'b0; mask_wdata = '0;
    cpu_ack = 1'b0; cpu_ack_ina = 1'b0; eoi = 1'b0;
    doReset(8'h00);

    // Single line: capture, request two cycles after the edge, ack, eoi.
    applyStimulus("mask", 8'h00, 0, 1, 8'hFF, 0, 0, 0,  0, 0, 0, 3'd0, 8'h00);
    applyStimulus("irq3", 8'h08, 0, 0, 8'h00, 0, 0, 0,  0, 0, 0, 3'd0, 8'h08);
    applyStimulus("req3", 8'h00, 0, 0, 8'h00, 0, 0, 0,  1, 0, 0, 3'd3, 8'h08);
    applyStimulus("ack3", 8'h00, 0, 0, 8'h00, 1, 1, 0,  0, 0, 1, 3'd3, 8'h00);
    applyStimulus("eoi3", 8'h00, 0, 0, 8'h00, 0, 0, 1,  0, 0, 0, 3'd3, 8'h00);

    // Simultaneous lines 5 and 2: lower index first.
    applyStimulus("irq52", 8'h24, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 3'd3, 8'h24);
    applyStimulus("req2",  8'h00, 0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 3'd2, 8'h24);
    applyStimulus("ack2",  8'h00, 0, 0, 8'h00, 1, 1, 0, 0, 0, 1, 3'd2, 8'h20);
    applyStimulus("eoi2",  8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 3'd2, 8'h20);
    applyStimulus("req5",  8'h00, 0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 3'd5, 8'h20);
    applyStimulus("ack5",  8'h00, 0, 0, 8'h00, 1, 1, 0, 0, 0, 1, 3'd5, 8'h00);
    applyStimulus("eoi5",  8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 3'd5, 8'h00);

    // NMI nested inside a maskable handler; eoi retires NMI first.
    applyStimulus("irq1",   8'h02, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 3'd5, 8'h02);
    applyStimulus("req1",   8'h00, 0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 3'd1, 8'h02);
    applyStimulus("ack1",   8'h00, 0, 0, 8'h00, 1, 1, 0, 0, 0, 1, 3'd1, 8'h00);
    applyStimulus("nmiIn",  8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 1, 1, 3'd1, 8'h00);
    applyStimulus("nmiAck", 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 0, 1, 3'd1, 8'h00);
    applyStimulus("eoiNmi", 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0, 1, 3'd1, 8'h00);
    applyStimulus("eoiInt", 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 3'd1, 8'h00);

    // Masked capture, late enable (old mask used that cycle), then withdrawal by mask clear.
    applyStimulus("mask0",   8'h00, 0, 1, 8'h00, 0, 0, 0, 0, 0, 0, 3'd1, 8'h00);
    applyStimulus("irq4m",   8'h10, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 3'd1, 8'h10);
    applyStimulus("idle4m",  8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 3'd1, 8'h10);
    applyStimulus("mask10",  8'h00, 0, 1, 8'h10, 0, 0, 0, 0, 0, 0, 3'd1, 8'h10);
    applyStimulus("req4",    8'h00, 0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 3'd4, 8'h10);
    applyStimulus("maskClr", 8'h00, 0, 1, 8'h00, 0, 0, 0, 1, 0, 0, 3'd4, 8'h10);
    applyStimulus("withdrw", 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 3'd4, 8'h10);

    // Acks and eoi that match nothing leave everything unchanged.
    applyStimulus("spurAck", 8'h00, 0, 0, 8'h00, 1, 1, 0, 0, 0, 0, 3'd4, 8'h10);
    applyStimulus("spurEoi", 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 3'd4, 8'h10);
    applyStimulus("spurNmi", 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 3'd4, 8'h10);

    // Re-enable, ack while line 4 rises again (set wins), then reset mid-service.
    applyStimulus("maskFF",  8'h00, 0, 1, 8'hFF, 0, 0, 0, 0, 0, 0, 3'd4, 8'h10);
    applyStimulus("req4b",   8'h00, 0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 3'd4, 8'h10);
    applyStimulus("ackSet",  8'h10, 0, 0, 8'h00, 1, 1, 0, 0, 0, 1, 3'd4, 8'h10);
    doReset(8'h00);

    // Lines 0 and 1 re-asserted at every eoi: fixed priority always picks 0, rotation alternates.
    applyStimulus("rMask", 8'h00, 0, 1, 8'hFF, 0, 0, 0, 0, 0, 0, 3'd0, 8'h00);
    applyStimulus("rIrq",  8'h03, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 3'd0, 8'h03);
    for (int k = 0; k < 4; k++) begin
      e = rotId(k);
      leftover = 8'h03 & ~(8'h01 << e);
      applyStimulus($sformatf("rReq%0d", k), 8'h03, 0, 0, 8'h00, 0, 0, 0, 1, 0, 0, e, 8'h03);
      applyStimulus($sformatf("rAck%0d", k), 8'h00, 0, 0, 8'h00, 1, 1, 0, 0, 0, 1, e, leftover);
      applyStimulus($sformatf("rEoi%0d", k), 8'h03, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0, e, 8'h03);
    end

    // Line held high across reset release counts as an edge.
    doReset(8'h04);
    applyStimulus("heldIrq", 8'h04, 0, 1, 8'hFF, 0, 0, 0, 0, 0, 0, 3'd0, 8'h04);
    applyStimulus("heldReq", 8'h04, 0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 3'd2, 8'h04);

    for (int w = 0; w < 5 && sbQueue.size() > 0; w++) begin
      @(posedge clk);
      #2;
    end
    if (sbQueue.size() > 0) begin
      checkOutput("sbDrain", 32'(sbQueue.size()), 32'd0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
